// File: rtl/averager_sample_ctrl.sv
// Sample-rate sequencer for the shared 2**POWER-sample moving averager: tick generation,
// source steering, window flush on source change and full-window qualification.
// Optional skipped-tick counter o_miss_cnt is built only when AVG_CTRL_MISS_CNT_EN is defined.
module averager_sample_ctrl #(
  parameter int POWER   = 8,
  parameter int N       = 12,
  parameter int NUM_SRC = 3,
  parameter int CLK_DIV = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           i_src_sel,
  input  logic [NUM_SRC*N-1:0] i_src_data,
  input  logic [NUM_SRC-1:0]   i_src_valid,
  input  logic [N-1:0]         i_avg_q,
  output logic [N-1:0]         o_avg_din,
  output logic                 o_avg_en,
  output logic                 o_avg_clr,
  output logic [2:0]           o_active_src,
  output logic                 o_filling,
  output logic [N-1:0]         o_out_data,
  output logic                 o_out_valid
`ifdef AVG_CTRL_MISS_CNT_EN
  ,
  output logic [7:0]           o_miss_cnt
`endif
);

  localparam int              CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]   TICK_LAST = CW'(CLK_DIV - 1);
  localparam logic [POWER:0]  FILL_FULL = {1'b1, {POWER{1'b0}}};
  localparam logic [3:0]      NSRC      = 4'(NUM_SRC);

  typedef enum logic [1:0] {
    S_FLUSH,
    S_FILL,
    S_RUN
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [CW-1:0]  r_tick_cnt;
  logic [POWER:0] r_fill_cnt;
  logic [POWER:0] w_fill_inc;
  logic [2:0]     r_src_sel;
  logic [2:0]     r_active_src;
  logic [N-1:0]   r_avg_din;
  logic           r_avg_en;
  logic           r_avg_clr;
  logic           r_en_d1;
  logic           r_filling;
  logic [N-1:0]   r_out_data;
  logic           r_out_valid;

  logic           w_tick;
  logic           w_change;
  logic           w_accept;
  logic           w_skip;
  logic [N-1:0]   w_sel_data;
  logic           w_sel_valid;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_sel_data  = '0;
    w_sel_valid = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (r_active_src == 3'(k)) begin
        w_sel_data  = i_src_data[k*N +: N];
        w_sel_valid = i_src_valid[k];
      end
    end
  end

  assign w_tick     = (r_tick_cnt == TICK_LAST);
  assign w_change   = ({1'b0, r_src_sel} < NSRC) && (r_src_sel != r_active_src);
  assign w_accept   = (r_state != S_FLUSH) && !w_change && w_tick && w_sel_valid;
  assign w_skip     = (r_state != S_FLUSH) && !w_change && w_tick && !w_sel_valid;
  assign w_fill_inc = r_fill_cnt + 1'b1;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FLUSH: w_state_next = S_FILL;
      S_FILL:  if (w_accept && (w_fill_inc == FILL_FULL)) w_state_next = S_RUN;
      S_RUN:   w_state_next = S_RUN;
      default: w_state_next = S_FLUSH;
    endcase
    // A source change overrides everything, including a change seen during FLUSH itself.
    if (w_change) w_state_next = S_FLUSH;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_FLUSH;
      r_tick_cnt   <= '0;
      r_fill_cnt   <= '0;
      r_src_sel    <= '0;
      r_active_src <= '0;
      r_avg_din    <= '0;
      r_avg_en     <= 1'b0;
      r_avg_clr    <= 1'b0;
      r_en_d1      <= 1'b0;
      r_filling    <= 1'b0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_src_sel <= i_src_sel;
      r_avg_clr <= (r_state == S_FLUSH);
      r_filling <= (w_state_next != S_RUN);
      r_avg_en  <= w_accept;
      r_en_d1   <= r_avg_en && !w_change && (r_state != S_FLUSH);

      if (w_accept) r_avg_din <= w_sel_data;
      if (w_change) r_active_src <= r_src_sel;

      if (r_state == S_FLUSH) begin
        r_tick_cnt <= '0;
        r_fill_cnt <= '0;
      end else begin
        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
        if (w_accept && (r_state == S_FILL)) r_fill_cnt <= w_fill_inc;
      end

      // Averager Q settles the cycle after avg_en; a capture in flight across a change is dropped.
      if (w_change || (r_state == S_FLUSH)) begin
        r_out_valid <= 1'b0;
      end else if (r_en_d1) begin
        r_out_data <= i_avg_q;
        if (r_fill_cnt == FILL_FULL) r_out_valid <= 1'b1;
      end
    end
  end

`ifdef AVG_CTRL_MISS_CNT_EN
  logic [7:0] r_miss_cnt;

  always_ff @(posedge clk) begin
    if (reset || (r_state == S_FLUSH)) begin
      r_miss_cnt <= '0;
    end else if (w_skip && (r_miss_cnt != 8'hFF)) begin
      r_miss_cnt <= r_miss_cnt + 1'b1;
    end
  end

  assign o_miss_cnt = r_miss_cnt;
`else
  logic w_skip_unused;
  assign w_skip_unused = w_skip;
`endif

  assign o_avg_din    = r_avg_din;
  assign o_avg_en     = r_avg_en;
  assign o_avg_clr    = r_avg_clr;
  assign o_active_src = r_active_src;
  assign o_filling    = r_filling;
  assign o_out_data   = r_out_data;
  assign o_out_valid  = r_out_valid;

endmodule

// File: tb/tb_averager_sample_ctrl.sv
// Directed bench for averager_sample_ctrl with a behavioural 4-sample moving averager attached.
module tb_averager_sample_ctrl;

  localparam int POWER   = 2;
  localparam int N       = 12;
  localparam int NUM_SRC = 3;
  localparam int CLK_DIV = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [2:0]           src_sel;
  logic [NUM_SRC*N-1:0] src_data;
  logic [NUM_SRC-1:0]   src_valid;
  logic [N-1:0]         avg_q;
  logic [N-1:0]         avg_din;
  logic                 avg_en;
  logic                 avg_clr;
  logic [2:0]           active_src;
  logic                 filling;
  logic [N-1:0]         out_data;
  logic                 out_valid;
`ifdef AVG_CTRL_MISS_CNT_EN
  logic [7:0]           miss_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  averager_sample_ctrl #(
    .POWER(POWER), .N(N), .NUM_SRC(NUM_SRC), .CLK_DIV(CLK_DIV)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_src_sel    (src_sel),
    .i_src_data   (src_data),
    .i_src_valid  (src_valid),
    .i_avg_q      (avg_q),
    .o_avg_din    (avg_din),
    .o_avg_en     (avg_en),
    .o_avg_clr    (avg_clr),
    .o_active_src (active_src),
    .o_filling    (filling),
    .o_out_data   (out_data),
    .o_out_valid  (out_valid)
`ifdef AVG_CTRL_MISS_CNT_EN
    ,
    .o_miss_cnt   (miss_cnt)
`endif
  );

  // Behavioural moving averager: window of 4 samples, Q = sum / 4, synchronous clear.
  logic [N+POWER-1:0] m_sum;
  logic [N-1:0]       m_win [4];

  always @(posedge clk) begin
    if (avg_clr || reset) begin
      m_sum <= '0;
      for (int i = 0; i < 4; i++) m_win[i] <= '0;
    end else if (avg_en) begin
      m_sum <= m_sum + {{POWER{1'b0}}, avg_din} - {{POWER{1'b0}}, m_win[3]};
      m_win[0] <= avg_din;
      for (int i = 1; i < 4; i++) m_win[i] <= m_win[i-1];
    end
  end

  assign avg_q = m_sum[N+POWER-1:POWER];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advances until avg_en is seen or the budget runs out; returns the edge count.
  task automatic wait_en(input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (avg_en !== 1'b1 && n < budget);
  endtask

  initial begin
    int n;
    logic saw;

    reset     = 1'b1;
    src_sel   = 3'd0;
    src_data  = {12'h040, 12'h0AA, 12'h100};
    src_valid = 3'b111;
    repeat (3) step();

    check("reset_avg_clr",    avg_clr,    0);
    check("reset_avg_en",     avg_en,     0);
    check("reset_out_valid",  out_valid,  0);
    check("reset_filling",    filling,    0);
    check("reset_active_src", active_src, 0);
    check("reset_out_data",   out_data,   0);
    check("reset_avg_din",    avg_din,    0);

    // Reset release: clear pulse, then first sample 4 clocks later.
    reset = 1'b0;
    step();
    check("flush_avg_clr_hi", avg_clr, 1);
    check("flush_filling",    filling, 1);
    wait_en(20, n);
    check("first_en_latency", n, 4);
    check("first_avg_din",    avg_din, 12'h100);
    check("first_out_valid",  out_valid, 0);
    for (int k = 2; k <= 4; k++) begin
      wait_en(20, n);
      check("src0_en_period", n, 4);
    end
    check("src0_filling_after_4", filling, 0);
    step();
    check("src0_valid_not_yet", out_valid, 0);
    step();
    check("src0_out_valid", out_valid, 1);
    check("src0_out_data",  out_data, 12'h100);

    // Source change 0 -> 2 while running.
    src_sel = 3'd2;
    step();
    check("chg_active_old",  active_src, 0);
    step();
    check("chg_active_new",  active_src, 2);
    check("chg_valid_drop",  out_valid, 0);
    step();
    check("chg_avg_clr",     avg_clr, 1);
    for (int k = 1; k <= 4; k++) begin
      wait_en(20, n);
      check("src2_en_period", n, 4);
      check("src2_avg_din",   avg_din, 12'h040);
    end
    step();
    check("src2_valid_not_yet", out_valid, 0);
    step();
    check("src2_out_valid", out_valid, 1);
    check("src2_out_data",  out_data, 12'h040);

    // Out-of-range select is ignored.
    src_sel = 3'd5;
    saw = 1'b0;
    repeat (12) begin
      step();
      if (avg_clr || !out_valid) saw = 1'b1;
    end
    check("sel5_no_flush",  saw, 0);
    check("sel5_active",    active_src, 2);
    check("sel5_out_data",  out_data, 12'h040);
    check("sel5_out_valid", out_valid, 1);

    // Back to source 0, then drop its valid for two ticks mid-fill.
    src_sel = 3'd0;
    step();
    step();
    check("chg0_active", active_src, 0);
    step();
    check("chg0_avg_clr", avg_clr, 1);
    wait_en(20, n);
    check("miss_en1", n, 4);
    wait_en(20, n);
    check("miss_en2", n, 4);
    src_valid[0] = 1'b0;
    saw = 1'b0;
    repeat (8) begin
      step();
      if (avg_en) saw = 1'b1;
    end
    check("miss_no_en", saw, 0);
    check("miss_still_filling", filling, 1);
    src_valid[0] = 1'b1;
    wait_en(20, n);
    check("miss_en3_late", n, 4);
    wait_en(20, n);
    check("miss_en4", n, 4);
    check("miss_filling_done", filling, 0);
`ifdef AVG_CTRL_MISS_CNT_EN
    check("miss_cnt", miss_cnt, 2);
`endif
    step();
    step();
    check("miss_out_valid", out_valid, 1);
    check("miss_out_data",  out_data, 12'h100);

    // Reset in the middle of a fill after two samples.
    src_sel = 3'd2;
    step();
    step();
    step();
    check("rst_pre_clr", avg_clr, 1);
    wait_en(20, n);
    check("rst_pre_en1", n, 4);
    wait_en(20, n);
    check("rst_pre_en2", n, 4);
    reset   = 1'b1;
    src_sel = 3'd0;
    step();
    check("midrst_active",    active_src, 0);
    check("midrst_avg_en",    avg_en, 0);
    check("midrst_filling",   filling, 0);
    check("midrst_out_data",  out_data, 0);
    check("midrst_out_valid", out_valid, 0);
    step();
    reset = 1'b0;
    step();
    check("post_rst_clr", avg_clr, 1);
    for (int k = 1; k <= 4; k++) begin
      wait_en(20, n);
      check("post_rst_en_period", n, 4);
      check("post_rst_valid_low", out_valid, 0);
    end
    step();
    check("post_rst_valid_not_yet", out_valid, 0);
    step();
    check("post_rst_out_valid", out_valid, 1);
    check("post_rst_out_data",  out_data, 12'h100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
